fetch_unit: RTL and testbench



---
 rtl/fetch_unit_if.sv | 39 +++
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch unit channel bundle: instruction-memory request/response, redirect
// from branch resolution, and the decoded head-of-queue view for decode.
//   master : fetch_unit side (drives requests and the decode view)
//   slave  : environment side (memory, branch unit, decode)
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output id_valid, id_pc, id_instr, opcode, func3, func7, rd, rs1, rs2,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  id_valid, id_pc, id_instr, opcode, func3, func7, rd, rs1, rs2,
    output id_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the PC, issues word-aligned reads to
// instruction memory under a credit limit of DEPTH (outstanding + queued),
// buffers in-order responses in a DEPTH-entry queue tagged with their PC and
// presents the head to decode. A redirect flushes the queue and marks every
// in-flight request for dropping.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - fetch_unit_if.master (imem req/rsp, redirect, decode view)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [AW-1:0] q_rd, q_wr, t_rd, t_wr;
  entry_t        q_mem   [DEPTH];
  logic [31:0]   tag_mem [DEPTH];

  logic   credit_ok;
  logic   req_fire;
  logic   rsp_keep;
  logic   pop;
  entry_t head;
  logic   unused_redirect_lsb;

  // Issue credit from registered counters only; a same-cycle pop does not help.
  assign credit_ok = (SW'(outstanding) + SW'(count)) < SW'(DEPTH);

  assign bus.imem_req_valid = !rst && !bus.redirect_valid && credit_ok;
  assign bus.imem_req_addr  = pc;

  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_keep = bus.imem_rsp_valid && (drop == '0);
  assign pop      = bus.id_valid && bus.id_ready;

  // Decode view of the queue head; NOP fields when empty.
  assign head         = q_mem[q_rd];
  assign bus.id_valid = (count != '0);
  assign bus.id_pc    = bus.id_valid ? head.pc : 32'h0;
  assign bus.id_instr = bus.id_valid ? head.instr : NOP;
  assign bus.opcode   = bus.id_instr[6:0];
  assign bus.func3    = bus.id_instr[14:12];
  assign bus.func7    = bus.id_instr[31:25];
  assign bus.rd       = bus.id_instr[11:7];
  assign bus.rs1      = bus.id_instr[19:15];
  assign bus.rs2      = bus.id_instr[24:20];

  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  // PC, credit/drop counters and queue pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      q_rd        <= '0;
      q_wr        <= '0;
      t_rd        <= '0;
      t_wr        <= '0;
    end else if (bus.redirect_valid) begin
      pc          <= {bus.redirect_pc[31:2], 2'b00};
      // Every request still in flight, including ones already marked, is
      // dropped; a response landing this cycle is consumed as a drop here.
      outstanding <= outstanding - CW'(bus.imem_rsp_valid);
      drop        <= outstanding - CW'(bus.imem_rsp_valid);
      count       <= '0;
      q_rd        <= '0;
      q_wr        <= '0;
      t_rd        <= '0;
      t_wr        <= '0;
    end else begin
      if (req_fire) begin
        pc   <= pc + 32'd4;
        t_wr <= t_wr + AW'(1);
      end
      outstanding <= outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);
      if (bus.imem_rsp_valid && (drop != '0)) begin
        drop <= drop - CW'(1);
      end
      if (rsp_keep) begin
        q_wr <= q_wr + AW'(1);
        t_rd <= t_rd + AW'(1);
      end
      if (pop) begin
        q_rd <= q_rd + AW'(1);
      end
      count <= count + CW'(rsp_keep) - CW'(pop);
    end
  end

  // Tag queue holds PCs of live (non-dropped) requests in issue order.
  always_ff @(posedge clk) begin
    if (!rst && !bus.redirect_valid) begin
      if (req_fire) begin
        tag_mem[t_wr] <= pc;
      end
      if (rsp_keep) begin
        q_mem[q_wr] <= {tag_mem[t_rd], bus.imem_rsp_data};
      end
    end
  end

  // Credit limit makes a push into a full queue without a pop impossible.
  always_ff @(posedge clk) begin
    if (!rst && !bus.redirect_valid) begin
      assert (!(rsp_keep && !pop && (count == CW'(DEPTH))))
        else $error("fetch_unit: instruction queue overflow");
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios pinned with literal values, then a
// randomized run compared every cycle against a queue-level reference model.
module tb_fetch_unit;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          live;
  } req_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if bus ();
  fetch_unit_if bus2 ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus.master)
  );
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.master)
  );

  // Reference model state: requests in flight (with a live flag cleared by
  // redirect) and the instruction queue presented to decode.
  req_t        mem_q[$];
  ent_t        fifo[$];
  logic [31:0] mpc;
  int          cyc = 0;
  int          last_due = 0;
  bit          model_ok = 1'b0;

  // Second instance: fixed one-cycle memory echoing the address.
  logic        r2_valid = 1'b0;
  logic [31:0] r2_data  = 32'h0;

  int checks   = 0;
  int failures = 0;

  int          rdy_pct   = 100;
  int          idr_pct   = 100;
  int          redir_pct = 0;
  int          rst_pm    = 0;
  bit          rand_rst  = 1'b0;
  bit          rst_ctl   = 1'b1;
  int          fixed_k   = 1;
  bit          rand_k    = 1'b0;
  int          data_mode = 0;
  bit          redir_req = 1'b0;
  logic [31:0] redir_addr = 32'h0;

  function automatic logic [31:0] datafn(input logic [31:0] a);
    case (data_mode)
      0:       return a;
      1:       return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
      default: return 32'h00A0_0513;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Advance the model across one rising edge using the inputs held stable.
  task automatic model_edge();
    bit   fire;
    req_t e;
    ent_t ent;
    int   k;
    if (rst) begin
      mem_q.delete();
      fifo.delete();
      mpc      = 32'h0000_0000;
      last_due = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      fire = !bus.redirect_valid && (mem_q.size() + fifo.size() < DEPTH) && bus.imem_req_ready;
      if (fifo.size() > 0 && bus.id_ready) void'(fifo.pop_front());
      if (bus.imem_rsp_valid && mem_q.size() > 0) begin
        e = mem_q.pop_front();
        if (e.live && !bus.redirect_valid) begin
          ent = {e.addr, bus.imem_rsp_data};
          fifo.push_back(ent);
        end
      end
      if (fire) begin
        k = rand_k ? int'($urandom_range(1, 4)) : fixed_k;
        e.addr = mpc;
        e.due  = (cyc + k > last_due) ? cyc + k : last_due + 1;
        e.live = 1'b1;
        last_due = e.due;
        mem_q.push_back(e);
        mpc = mpc + 32'd4;
      end
      if (bus.redirect_valid) begin
        foreach (mem_q[i]) mem_q[i].live = 1'b0;
        fifo.delete();
        mpc = {bus.redirect_pc[31:2], 2'b00};
      end
    end
    r2_valid = !rst && bus2.imem_req_valid && bus2.imem_req_ready;
    r2_data  = bus2.imem_req_addr;
    cyc++;
  endtask

  task automatic compare_all();
    ent_t h;
    bit   ev;
    ev = (fifo.size() > 0);
    h  = ev ? fifo[0] : {32'h0, NOP};
    chk("req_valid", 32'(bus.imem_req_valid),
        32'(!rst && !bus.redirect_valid && (mem_q.size() + fifo.size() < DEPTH)));
    chk("req_addr", bus.imem_req_addr, mpc);
    chk("id_valid", 32'(bus.id_valid), 32'(ev));
    chk("id_pc", bus.id_pc, h.pc);
    chk("id_instr", bus.id_instr, h.instr);
    chk("opcode", 32'(bus.opcode), 32'(h.instr[6:0]));
    chk("func3", 32'(bus.func3), 32'(h.instr[14:12]));
    chk("func7", 32'(bus.func7), 32'(h.instr[31:25]));
    chk("rd", 32'(bus.rd), 32'(h.instr[11:7]));
    chk("rs1", 32'(bus.rs1), 32'(h.instr[19:15]));
    chk("rs2", 32'(bus.rs2), 32'(h.instr[24:20]));
  endtask

  // One clock: model edge, drive next-cycle inputs on the falling edge, check.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    rst = rand_rst ? ($urandom_range(0, 999) < rst_pm) : rst_ctl;
    bus.imem_req_ready = ($urandom_range(0, 99) < rdy_pct);
    bus.id_ready       = ($urandom_range(0, 99) < idr_pct);
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = $urandom();
    if (redir_req) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = redir_addr;
      redir_req          = 1'b0;
    end else if ($urandom_range(0, 99) < redir_pct) begin
      bus.redirect_valid = 1'b1;
    end
    if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = datafn(mem_q[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom();
    end
    bus2.imem_req_ready = 1'b1;
    bus2.id_ready       = 1'b1;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = 32'h0;
    bus2.imem_rsp_valid = r2_valid && !rst;
    bus2.imem_rsp_data  = r2_data;
    #1;
    if (model_ok) compare_all();
  endtask

  initial begin
    int nf;
    bit found;
    rst = 1'b1;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0; bus.id_ready = 1'b0;
    bus2.imem_req_ready = 1'b0; bus2.imem_rsp_valid = 1'b0; bus2.imem_rsp_data = 32'h0;
    bus2.redirect_valid = 1'b0; bus2.redirect_pc = 32'h0; bus2.id_ready = 1'b0;

    // Reset state.
    step(); step();
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
    chk("rst_id_instr", bus.id_instr, NOP);
    chk("rst_id_pc", bus.id_pc, 32'h0);
    chk("rst_pc", bus.imem_req_addr, 32'h0);
    chk("rst_pc2", bus2.imem_req_addr, 32'hFFFF_FFFC);

    // Streaming at k=1 with everything ready; second instance wraps the PC.
    rst_ctl = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 1) begin
        chk("s_addr1", bus.imem_req_addr, 32'h0);
        chk("s_valid1", 32'(bus.imem_req_valid), 32'd1);
        chk("w_addr1", bus2.imem_req_addr, 32'hFFFF_FFFC);
      end
      if (i == 2) begin
        chk("s_addr2", bus.imem_req_addr, 32'h4);
        chk("w_addr2", bus2.imem_req_addr, 32'h0);
      end
      if (i <= 2) chk("s_idv_lo", 32'(bus.id_valid), 32'd0);
      if (i >= 3) begin
        chk("s_idv_hi", 32'(bus.id_valid), 32'd1);
        chk("s_id_pc", bus.id_pc, 32'(4 * (i - 3)));
        chk("s_id_instr", bus.id_instr, 32'(4 * (i - 3)));
      end
      if (i == 3) chk("w_id_pc3", bus2.id_pc, 32'hFFFF_FFFC);
      if (i == 4) begin
        chk("w_id_pc4", bus2.id_pc, 32'h0);
        chk("w_id_instr4", bus2.id_instr, 32'h0);
      end
    end

    // Decode stalled: exactly DEPTH requests, then drain in order.
    rst_ctl = 1'b1; step();
    rst_ctl = 1'b0; idr_pct = 0; nf = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        chk("bp_addr", bus.imem_req_addr, 32'(nf * 4));
        nf++;
      end
    end
    chk("bp_nreq", 32'(nf), 32'd4);
    chk("bp_stall", 32'(bus.imem_req_valid), 32'd0);
    idr_pct = 100;
    step();
    chk("bp_pop0", bus.id_pc, 32'h0);
    chk("bp_nolook", 32'(bus.imem_req_valid), 32'd0);
    step();
    chk("bp_pop4", bus.id_pc, 32'h4);
    chk("bp_resume_v", 32'(bus.imem_req_valid), 32'd1);
    chk("bp_resume_a", bus.imem_req_addr, 32'h10);
    step(); chk("bp_pop8", bus.id_pc, 32'h8);
    step(); chk("bp_popc", bus.id_pc, 32'hC);

    // k=3 redirect with responses still in flight.
    rst_ctl = 1'b1; step();
    rst_ctl = 1'b0; fixed_k = 3;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) begin redir_req = 1'b1; redir_addr = 32'h0000_0200; end
      step();
    end
    chk("k3_head_v", 32'(bus.id_valid), 32'd1);
    chk("k3_head_pc", bus.id_pc, 32'h0);
    found = 1'b0;
    for (int n = 1; n <= 20 && !found; n++) begin
      step();
      if (bus.id_valid) begin
        found = 1'b1;
        chk("k3_lat", 32'(n), 32'd5);
        chk("k3_pc", bus.id_pc, 32'h200);
      end
    end
    chk("k3_found", 32'(found), 32'd1);

    // Misaligned redirect target is forced to a word boundary.
    fixed_k = 1;
    step(); step(); step();
    redir_req = 1'b1; redir_addr = 32'h0000_0103;
    step();
    chk("al_noreq", 32'(bus.imem_req_valid), 32'd0);
    step();
    chk("al_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("al_addr", bus.imem_req_addr, 32'h100);
    found = 1'b0;
    for (int n = 1; n <= 10 && !found; n++) begin
      step();
      if (bus.id_valid) begin
        found = 1'b1;
        chk("al_id_pc", bus.id_pc, 32'h100);
      end
    end
    chk("al_found", 32'(found), 32'd1);

    // Field split of a known instruction, then reset mid-stream.
    data_mode = 2;
    rst_ctl = 1'b1; step();
    rst_ctl = 1'b0;
    found = 1'b0;
    for (int n = 1; n <= 10 && !found; n++) begin
      step();
      if (bus.id_valid) found = 1'b1;
    end
    chk("f_found", 32'(found), 32'd1);
    chk("f_instr", bus.id_instr, 32'h00A0_0513);
    chk("f_opcode", 32'(bus.opcode), 32'h13);
    chk("f_func3", 32'(bus.func3), 32'd0);
    chk("f_func7", 32'(bus.func7), 32'd0);
    chk("f_rd", 32'(bus.rd), 32'd10);
    chk("f_rs1", 32'(bus.rs1), 32'd0);
    chk("f_rs2", 32'(bus.rs2), 32'd10);
    step(); step();
    rst_ctl = 1'b1;
    step(); step();
    chk("mr_id_valid", 32'(bus.id_valid), 32'd0);
    chk("mr_id_instr", bus.id_instr, NOP);
    chk("mr_pc", bus.imem_req_addr, 32'h0);
    chk("mr_req_valid", 32'(bus.imem_req_valid), 32'd0);
    rst_ctl = 1'b0;

    // Randomized traffic: stalls, variable latency, redirects, resets.
    data_mode = 1; rand_k = 1'b1;
    rdy_pct = 70; idr_pct = 70; redir_pct = 4;
    rst_pm = 3; rand_rst = 1'b1;
    for (int i = 0; i < 1500; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
